// File: rtl/nibble_serial_adder_ctrl_if.sv
// Operand request and result handshake bundle for nibble_serial_adder_ctrl.
// out_ovf exists only when NIBBLE_ADDER_OVF_EN is defined.
interface nibble_serial_adder_ctrl_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
`ifdef NIBBLE_ADDER_OVF_EN
  logic             out_ovf;

  modport master (
    output in_valid, op_a, op_b, op_cin, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf
  );
  modport slave (
    input  in_valid, op_a, op_b, op_cin, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf
  );
`else
  modport master (
    output in_valid, op_a, op_b, op_cin, out_ready,
    input  in_ready, out_valid, out_sum, out_cout
  );
  modport slave (
    input  in_valid, op_a, op_b, op_cin, out_ready,
    output in_ready, out_valid, out_sum, out_cout
  );
`endif
endinterface

// File: rtl/nibble_serial_adder_ctrl.sv
// Serial WIDTH-bit adder around an external 4-bit CLA, LSB nibble first; out_valid NNIB cycles after accept,
// result held until out_ready, no accept outside IDLE. NIBBLE_ADDER_OVF_EN adds signed-overflow out_ovf.
module nibble_serial_adder_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  nibble_serial_adder_ctrl_if.slave  bus,
  output logic [3:0]                 cla_a,
  output logic [3:0]                 cla_b,
  output logic                       cla_cin,
  input  logic [3:0]                 cla_sum,
  input  logic                       cla_cout,
  output logic                       busy
);
  localparam int NNIB  = WIDTH / 4;
  localparam int IDX_W = $clog2(NNIB);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic             carry_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             out_valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      carry_reg   <= 1'b0;
      a_reg       <= '0;
      b_reg       <= '0;
      sum_reg     <= '0;
      out_valid_q <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_reg     <= bus.op_a;
            b_reg     <= bus.op_b;
            carry_reg <= bus.op_cin;
            idx       <= '0;
            busy      <= 1'b1;
            state     <= RUN;
          end
        end
        RUN: begin
          sum_reg[4*idx +: 4] <= cla_sum;
          carry_reg           <= cla_cout;
          idx                 <= idx + 1'b1;
          if (idx == IDX_W'(NNIB - 1)) begin
            idx         <= '0;
            out_valid_q <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          // A pending in_valid waits for IDLE so the result handshake never overlaps an accept.
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            busy        <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // CLA inputs come only from registers, so the external slice cannot close a loop.
  always_comb begin
    cla_a   = 4'd0;
    cla_b   = 4'd0;
    cla_cin = 1'b0;
    if (state == RUN) begin
      cla_a   = a_reg[4*idx +: 4];
      cla_b   = b_reg[4*idx +: 4];
      cla_cin = carry_reg;
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = sum_reg;
  assign bus.out_cout  = carry_reg;

`ifdef NIBBLE_ADDER_OVF_EN
  assign bus.out_ovf = (state == DONE) &&
                       (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                       (sum_reg[WIDTH-1] != a_reg[WIDTH-1]);
`endif
endmodule
